iterative_alu: RTL and testbench
================================

ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; legal range 8..64.
REQ-002 Parameter FRAC, default 16: fixed-point fraction bits; legal range 1..WIDTH-1.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request; accepted on an edge where start=1 and ready=1.
REQ-006 abort  input  1  cancels an in-flight operation.
REQ-007 a  input  WIDTH  operand A (dividend / multiplicand).
REQ-008 b  input  WIDTH  operand B (divisor / multiplier).
REQ-009 opcode  input  4  0 MULTS, 1 MULTU, 2 MULTFP, 3 DIVS, 4 DIVU, 5 DIVFP, 6 MODS, 7 MODU; 8..15 unsupported.
REQ-010 ready  output  1  high only in IDLE; combinational from state.
REQ-011 y  output  WIDTH  registered result; holds until the next done.
REQ-012 done  output  1  registered one-cycle completion pulse.
REQ-013 div_by_zero  output  1  registered; valid with done; 1 when a divide/modulo op had b=0.
REQ-014 illegal  output  1  registered; valid with done; 1 for unsupported opcode.

Function
REQ-015 States: IDLE, MUL, DIV, FIX, DONE; IDLE->MUL/DIV on accept; MUL/DIV->FIX after the last iteration; FIX->DONE; DONE->IDLE unconditionally.
REQ-016 Operands and opcode are latched on the accept edge (T0); later input changes have no effect.
REQ-017 Multiply: radix-2 shift-add on operand magnitudes, one bit per cycle, WIDTH iterations, 2*WIDTH-bit product; FIX negates the product when signed and operand signs differ.
REQ-018 MULTS/MULTU return product[WIDTH-1:0]; MULTFP returns signed product[WIDTH+FRAC-1:FRAC].
REQ-019 Divide: radix-2 restoring division on magnitudes; WIDTH iterations for DIV/MOD, WIDTH+FRAC iterations for DIVFP with dividend |a| shifted left by FRAC.
REQ-020 Signed quotient truncates toward zero; signed remainder takes the dividend's sign; DIVS of most-negative by -1 returns most-negative, MODS returns 0.
REQ-021 done shall pulse at T0+WIDTH+2 (mul, div, mod) or T0+WIDTH+FRAC+2 (DIVFP), i.e. in DONE state.
REQ-022 b=0 on opcodes 3..7: skip iterations; done at T0+2; div_by_zero=1; DIV* return all-ones, MOD* return a.
REQ-023 Unsupported opcode: done at T0+1 with illegal=1, y=0, div_by_zero=0.
REQ-024 done, div_by_zero and illegal are 0 in every cycle except the completion cycle.
REQ-025 start while ready=0 is ignored; ready=1 during the done cycle is not required (next accept is the edge after done).
REQ-026 abort=1 in MUL, DIV or FIX: next edge returns to IDLE, no done, y unchanged; abort in IDLE or DONE is ignored.
REQ-027 abort and start on the same edge in IDLE: start is accepted.

Reset
REQ-028 reset_n=0 on an edge shall force IDLE, y=0, done=0, div_by_zero=0, illegal=0, clearing all iteration counters and datapath registers.
REQ-029 Reset mid-operation shall discard the operation with no done pulse; reset has priority over abort and start.

Configuration
REQ-030 Macro ITERATIVE_ALU_FIXEDPOINT_EN defined: MULTFP and DIVFP shall operate as specified.
REQ-031 Macro undefined: opcodes 2 and 5 shall be treated as unsupported per REQ-023, and the FRAC-extended divider logic shall be omitted.

Verification (WIDTH=32, FRAC=16, macro defined unless noted)
REQ-032 MULTS a=0xFFFFFFFD, b=7 -> y=0xFFFFFFEB, single done pulse at T0+34; MULTU 0xFFFFFFFF*2 -> y=0xFFFFFFFE.
REQ-033 DIVS a=-7, b=2 -> y=0xFFFFFFFD; MODS same operands -> y=0xFFFFFFFF; DIVS 0x80000000/0xFFFFFFFF -> y=0x80000000.
REQ-034 DIVU a=100, b=0 -> done at T0+2, div_by_zero=1, y=0xFFFFFFFF; MODU a=100, b=0 -> y=100.
REQ-035 MULTFP 0x00018000*0x00020000 -> y=0x00030000 at T0+34; DIVFP 0x00030000/0x00020000 -> y=0x00018000 at T0+50; macro undefined -> both give illegal=1, y=0 at T0+1.
REQ-036 DIVU with abort=1 at T0+5 -> no done, ready=1 at T0+6, new MULTU 3*4 accepted -> y=12; reset_n=0 mid-MULTU -> y=0, no done.
REQ-037 opcode 9 -> done at T0+1, illegal=1, y=0; start held high while busy -> exactly one done per accept.

Source files
------------

// File: rtl/iterative_alu.sv
`default_nettype none
// ============================================================================
// Module  : iterative_alu
// Brief   : Multi-cycle ALU: radix-2 shift-add multiply and restoring divide.
//           Define ITERATIVE_ALU_FIXEDPOINT_EN to enable MULTFP and DIVFP.
// Rev     : 1.0  initial release
// ============================================================================
module iterative_alu #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             ready,
    output logic [WIDTH-1:0] y,
    output logic             done,
    output logic             div_by_zero,
    output logic             illegal
);

    localparam logic [3:0] c_OP_MULTS  = 4'd0;
    localparam logic [3:0] c_OP_MULTU  = 4'd1;
    localparam logic [3:0] c_OP_MULTFP = 4'd2;
    localparam logic [3:0] c_OP_DIVS   = 4'd3;
    localparam logic [3:0] c_OP_DIVU   = 4'd4;
    localparam logic [3:0] c_OP_DIVFP  = 4'd5;
    localparam logic [3:0] c_OP_MODS   = 4'd6;
    localparam logic [3:0] c_OP_MODU   = 4'd7;

`ifdef ITERATIVE_ALU_FIXEDPOINT_EN
    localparam int c_QW = WIDTH + FRAC;
`else
    localparam int c_QW = WIDTH;
`endif
    localparam int                 c_CNT_W = $clog2(WIDTH + FRAC + 1);
    localparam logic [c_CNT_W-1:0] c_ITER  = c_CNT_W'(WIDTH);
`ifdef ITERATIVE_ALU_FIXEDPOINT_EN
    localparam logic [c_CNT_W-1:0] c_ITER_FP = c_CNT_W'(WIDTH + FRAC);
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [c_QW-1:0]    lo_q, lo_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               zero_div_q, zero_div_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               done_q, done_d;
    logic               div_by_zero_q, div_by_zero_d;
    logic               illegal_q, illegal_d;

    logic               w_legal;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [c_QW-1:0]    w_div_init;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH+FRAC-1:0] w_prod;
    logic [WIDTH+FRAC-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_result;

    assign ready       = (state_q == S_IDLE);
    assign y           = y_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign illegal     = illegal_q;

    always_comb begin
        w_legal = (opcode[3] == 1'b0);
`ifndef ITERATIVE_ALU_FIXEDPOINT_EN
        if (opcode == c_OP_MULTFP || opcode == c_OP_DIVFP) begin
            w_legal = 1'b0;
        end
`endif
    end

    assign w_signed = (opcode == c_OP_MULTS) || (opcode == c_OP_MULTFP) ||
                      (opcode == c_OP_DIVS)  || (opcode == c_OP_DIVFP)  ||
                      (opcode == c_OP_MODS);
    assign w_mag_a  = (w_signed && a[WIDTH-1]) ? -a : a;
    assign w_mag_b  = (w_signed && b[WIDTH-1]) ? -b : b;

    // Divide dividend sits at the top of lo so DIV and DIVFP share one load.
`ifdef ITERATIVE_ALU_FIXEDPOINT_EN
    assign w_div_init = {w_mag_a, {FRAC{1'b0}}};
`else
    assign w_div_init = w_mag_a;
`endif

    assign w_mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    assign w_shift   = {hi_q, lo_q[c_QW-1]};
    assign w_qbit    = (w_shift >= {1'b0, opnd_q});
    assign w_sub     = w_shift[WIDTH-1:0] - opnd_q;

    assign w_prod   = {hi_q[FRAC-1:0], lo_q[WIDTH-1:0]};
    assign w_prod_s = neg_q ? -w_prod : w_prod;
    assign w_quo_s  = neg_q ? -lo_q[WIDTH-1:0] : lo_q[WIDTH-1:0];
    assign w_rem_s  = rem_neg_q ? -hi_q : hi_q;

    always_comb begin
        w_result = '0;
        if (zero_div_q) begin
            w_result = (op_q == c_OP_MODS || op_q == c_OP_MODU) ? a_q : '1;
        end else begin
            case (op_q)
                c_OP_MULTS, c_OP_MULTU:          w_result = w_prod_s[WIDTH-1:0];
                c_OP_MULTFP:                     w_result = w_prod_s[WIDTH+FRAC-1:FRAC];
                c_OP_DIVS, c_OP_DIVU, c_OP_DIVFP: w_result = w_quo_s;
                c_OP_MODS, c_OP_MODU:            w_result = w_rem_s;
                default:                         w_result = '0;
            endcase
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        opnd_d        = opnd_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        cnt_d         = cnt_q;
        neg_d         = neg_q;
        rem_neg_d     = rem_neg_q;
        zero_div_d    = zero_div_q;
        y_d           = y_q;
        done_d        = 1'b0;
        div_by_zero_d = 1'b0;
        illegal_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = opcode;
                    a_d        = a;
                    neg_d      = w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d  = w_signed && a[WIDTH-1];
                    zero_div_d = 1'b0;
                    if (!w_legal) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                        y_d       = '0;
                    end else if (opcode <= c_OP_MULTFP) begin
                        state_d = S_MUL;
                        hi_d    = '0;
                        lo_d    = c_QW'(w_mag_b);
                        opnd_d  = w_mag_a;
                        cnt_d   = c_ITER;
                    end else if (b == '0) begin
                        state_d    = S_FIX;
                        zero_div_d = 1'b1;
                    end else begin
                        state_d = S_DIV;
                        hi_d    = '0;
                        lo_d    = w_div_init;
                        opnd_d  = w_mag_b;
`ifdef ITERATIVE_ALU_FIXEDPOINT_EN
                        cnt_d   = (opcode == c_OP_DIVFP) ? c_ITER_FP : c_ITER;
`else
                        cnt_d   = c_ITER;
`endif
                    end
                end
            end
            S_MUL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d             = w_mul_sum[WIDTH:1];
                    lo_d[WIDTH-1:0]  = {w_mul_sum[0], lo_q[WIDTH-1:1]};
                    cnt_d            = cnt_q - 1'b1;
                    if (cnt_q == c_CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_DIV: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = w_qbit ? w_sub : w_shift[WIDTH-1:0];
                    lo_d  = {lo_q[c_QW-2:0], w_qbit};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == c_CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d       = S_DONE;
                    done_d        = 1'b1;
                    div_by_zero_d = zero_div_q;
                    y_d           = w_result;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            a_q           <= '0;
            opnd_q        <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            cnt_q         <= '0;
            neg_q         <= 1'b0;
            rem_neg_q     <= 1'b0;
            zero_div_q    <= 1'b0;
            y_q           <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            opnd_q        <= opnd_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            cnt_q         <= cnt_d;
            neg_q         <= neg_d;
            rem_neg_q     <= rem_neg_d;
            zero_div_q    <= zero_div_d;
            y_q           <= y_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
            illegal_q     <= illegal_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iterative_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_iterative_alu
// Brief   : Scoreboard bench for iterative_alu (WIDTH=32, FRAC=16); honours
//           ITERATIVE_ALU_FIXEDPOINT_EN in its reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_iterative_alu;

    localparam int W = 32;
    localparam int F = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [3:0]    opcode = '0;
    logic          ready;
    logic [W-1:0]  y;
    logic          done;
    logic          dbz;
    logic          ill;

    iterative_alu #(.WIDTH(W), .FRAC(F)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .ready       (ready),
        .y           (y),
        .done        (done),
        .div_by_zero (dbz),
        .illegal     (ill)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] y;
        logic        dbz;
        logic        ill;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_y = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic; due = edge after which done is visible.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] av,
                                   input logic [31:0] bv, input int t0);
        exp_t             e;
        longint           sa, sbv, r;
        longint unsigned  ua, ub, ur;
        bit               legal;
        sa    = longint'($signed(av));
        sbv   = longint'($signed(bv));
        ua    = {32'd0, av};
        ub    = {32'd0, bv};
        r     = 0;
        ur    = 0;
        legal = (op <= 4'd7);
`ifndef ITERATIVE_ALU_FIXEDPOINT_EN
        if (op == 4'd2 || op == 4'd5) legal = 1'b0;
`endif
        e.y   = '0;
        e.dbz = 1'b0;
        e.ill = 1'b0;
        if (!legal) begin
            e.ill = 1'b1;
            e.due = t0;
        end else if (op >= 4'd3 && bv == 32'd0) begin
            e.dbz = 1'b1;
            e.y   = (op >= 4'd6) ? av : 32'hFFFF_FFFF;
            e.due = t0 + 1;
        end else begin
            case (op)
                4'd0:    begin r = sa * sbv;           e.y = r[31:0];  end
                4'd1:    begin ur = ua * ub;           e.y = ur[31:0]; end
                4'd2:    begin r = sa * sbv;           e.y = r[47:16]; end
                4'd3:    begin r = sa / sbv;           e.y = r[31:0];  end
                4'd4:    begin ur = ua / ub;           e.y = ur[31:0]; end
                4'd5:    begin r = (sa * 65536) / sbv; e.y = r[31:0];  end
                4'd6:    begin r = sa % sbv;           e.y = r[31:0];  end
                default: begin ur = ua % ub;           e.y = ur[31:0]; end
            endcase
            e.due = t0 + W + 1 + ((op == 4'd5) ? F : 0);
        end
        return e;
    endfunction

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input bit push, input bit with_abort, output int t0);
        int n;
        n  = 0;
        t0 = -1;
        @(negedge clk);
        while (!ready) begin
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: ready=0 for %0d cycles, required 1", n);
                return;
            end
            @(negedge clk);
            n++;
        end
        opcode = op;
        a      = av;
        b      = bv;
        start  = 1'b1;
        abort  = with_abort;
        t0     = cyc + 1;
        if (push) sb.push_back(model(op, av, bv, t0));
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        opcode = 4'($urandom);
    endtask

    task automatic run(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        int t0;
        issue(op, av, bv, 1'b1, 1'b0, t0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            check("rst_y", y, 0);
            check("rst_done", done, 0);
            check("rst_dbz", dbz, 0);
            check("rst_illegal", ill, 0);
            check("rst_ready", ready, 1);
            last_y = '0;
        end else if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no outstanding op, required 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result_y", y, mon_e.y);
                check("result_dbz", dbz, mon_e.dbz);
                check("result_illegal", ill, mon_e.ill);
                check("done_cycle", cyc, mon_e.due);
            end
            last_y = y;
        end else begin
            check("flags_idle", {dbz, ill}, 0);
            check("y_hold", y, last_y);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t0;
        int          n;
        logic [3:0]  op;
        logic [31:0] av, bv;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        run(4'd0, 32'hFFFF_FFFD, 32'd7);
        run(4'd1, 32'hFFFF_FFFF, 32'd2);
        run(4'd3, 32'hFFFF_FFF9, 32'd2);
        run(4'd6, 32'hFFFF_FFF9, 32'd2);
        run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run(4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run(4'd4, 32'd100, 32'd0);
        run(4'd7, 32'd100, 32'd0);
        run(4'd2, 32'h0001_8000, 32'h0002_0000);
        run(4'd5, 32'h0003_0000, 32'h0002_0000);
        run(4'd5, 32'hFFFD_0000, 32'h0002_0000);
        run(4'd3, 32'd5, 32'd0);
        run(4'd9, 32'd1, 32'd2);
        run(4'd15, 32'd1, 32'd2);
        issue(4'd0, 32'd6, 32'hFFFF_FFF9, 1'b1, 1'b1, t0);

        // Abort a DIVU, then a fresh MULTU must still work.
        issue(4'd4, 32'd1000, 32'd7, 1'b0, 1'b0, t0);
        while (cyc < t0 + 4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ready_after_abort", ready, 1);
        run(4'd1, 32'd3, 32'd4);

        // Reset in the middle of a MULTU.
        issue(4'd1, 32'd9, 32'd9, 1'b0, 1'b0, t0);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (W + 6) @(negedge clk);

        // start held high: one done per accept.
        @(negedge clk);
        opcode = 4'd1;
        a      = 32'd5;
        b      = 32'd6;
        start  = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (ready) sb.push_back(model(4'd1, 32'd5, 32'd6, cyc + 1));
            @(negedge clk);
        end
        start = 1'b0;

        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            av = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 9))
                0:       bv = 32'd0;
                1:       bv = $urandom_range(1, 15);
                2:       bv = 32'hFFFF_FFFF;
                default: bv = $urandom;
            endcase
            run(op, av, bv);
        end

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
